// File: rtl/evaluator_pkg.sv
// evaluator_pkg: shared types and constants for axis_expr_evaluator.
//   op_e      - result tag carried on out_dest (OP_ADD .. OP_CLOG2)
//   state_e   - evaluator FSM states
//   OP_COUNT  - beats per result set (6 with EVALUATOR_CLOG2_EN, else 5)
//   LAST_OP   - tag of the final beat of a set
//   clog2_u64 - ceil-log2 helper used by the optional clog2 unit
package evaluator_pkg;

   typedef enum logic [2:0] {
      OP_ADD   = 3'd0,
      OP_SUB   = 3'd1,
      OP_MUL   = 3'd2,
      OP_DIV   = 3'd3,
      OP_MOD   = 3'd4,
      OP_CLOG2 = 3'd5
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COMPUTE = 2'd1,
      ST_EMIT    = 2'd2
   } state_e;

`ifdef EVALUATOR_CLOG2_EN
   localparam int unsigned OP_COUNT = 6;
`else
   localparam int unsigned OP_COUNT = 5;
`endif

   localparam logic [2:0] LAST_OP = 3'(OP_COUNT - 1);

   // Smallest n with 2^n >= v: one more than the MSB index of v-1; 0 and 1 map to 0.
   function automatic logic [6:0] clog2_u64(input logic [63:0] v);
      logic [63:0] m;
      logic [6:0]  n;
      n = 7'd0;
      m = v - 64'd1;
      if (v > 64'd1) begin
         for (int i = 0; i < 64; i++) begin
            if (m[i]) begin
               n = 7'(i + 1);
            end else begin
               n = n;
            end
         end
      end else begin
         n = 7'd0;
      end
      return n;
   endfunction

endpackage

// File: rtl/serial_divider.sv
// serial_divider: restoring unsigned divider, one quotient bit per cycle.
//   clock, reset      - rising-edge clock, asynchronous active-low reset
//   start             - load dividend/divisor and begin (ignored while busy)
//   busy              - iterations in progress
//   done              - high during the final iteration; quotient/remainder
//                       are valid from the following cycle
//   quotient/remainder- results; divisor 0 gives all-ones quotient, remainder = dividend
module serial_divider
   import evaluator_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0] divisor,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] quotient,
   output logic [DATA_WIDTH-1:0] remainder
);

   localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

   logic                  busy_q, busy_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] quo_q, quo_d;
   logic [DATA_WIDTH-1:0] rem_q, rem_d;
   logic [DATA_WIDTH-1:0] den_q, den_d;
   logic [DATA_WIDTH:0]   shifted_s;
   logic [DATA_WIDTH:0]   diff_s;

   // Next-state: load on start, otherwise one restoring step per busy cycle.
   always_comb begin
      busy_d    = busy_q;
      cnt_d     = cnt_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      den_d     = den_q;
      // quo_q doubles as the dividend shift register; its MSB feeds the remainder.
      shifted_s = {rem_q, quo_q[DATA_WIDTH-1]};
      diff_s    = shifted_s - {1'b0, den_q};
      if (start && !busy_q) begin
         busy_d = 1'b1;
         cnt_d  = CNT_W'(DATA_WIDTH);
         quo_d  = dividend;
         rem_d  = '0;
         den_d  = divisor;
      end else if (busy_q) begin
         // diff_s MSB set means the trial subtraction went negative: restore.
         if (!diff_s[DATA_WIDTH]) begin
            rem_d = diff_s[DATA_WIDTH-1:0];
            quo_d = {quo_q[DATA_WIDTH-2:0], 1'b1};
         end else begin
            rem_d = shifted_s[DATA_WIDTH-1:0];
            quo_d = {quo_q[DATA_WIDTH-2:0], 1'b0};
         end
         cnt_d  = cnt_q - CNT_W'(1);
         busy_d = (cnt_q != CNT_W'(1));
      end else begin
         busy_d = 1'b0;
      end
   end

   // State registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         quo_q  <= '0;
         rem_q  <= '0;
         den_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         den_q  <= den_d;
      end
   end

   assign busy      = busy_q;
   assign done      = busy_q && (cnt_q == CNT_W'(1));
   // Restoring division already yields these for a zero divisor; the mux pins it down.
   assign quotient  = (den_q == '0) ? '1 : quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/axis_expr_evaluator.sv
// axis_expr_evaluator: evaluates add, sub, mul, div, mod (and clog2 when
// EVALUATOR_CLOG2_EN is defined) on an operand pair and streams one tagged
// result beat per operation.
//   clock, reset                 - rising-edge clock, asynchronous active-low reset
//   in_data/in_valid/in_ready    - operand pair slave port (a = low half, b = high half)
//   out_data/out_dest/out_tlast/
//   out_valid/out_ready          - result master port; out_dest carries the op tag
// All outputs are registered.
module axis_expr_evaluator
   import evaluator_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [2*DATA_WIDTH-1:0] in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [DATA_WIDTH-1:0]   out_data,
   output logic [2:0]              out_dest,
   output logic                    out_tlast,
   output logic                    out_valid,
   input  logic                    out_ready
);

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [DATA_WIDTH-1:0] add_q, add_d, sub_q, sub_d, mul_q, mul_d;
`ifdef EVALUATOR_CLOG2_EN
   logic [DATA_WIDTH-1:0] clog2_q, clog2_d;
`endif
   logic [2:0]            idx_q, idx_d;
   logic                  in_ready_q, in_ready_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [2:0]            out_dest_q, out_dest_d;
   logic                  out_tlast_q, out_tlast_d;

   logic                  in_hs_s, out_hs_s;
   logic                  div_busy_s, div_done_s;
   logic [DATA_WIDTH-1:0] div_quo_s, div_rem_s;
   logic [2:0]            nxt_idx_s;
   logic [DATA_WIDTH-1:0] nxt_data_s;

   assign in_hs_s  = in_valid && in_ready_q;
   assign out_hs_s = out_valid_q && out_ready;

   // Divider starts on the input handshake straight from in_data, so it finishes
   // on the same cycle boundary that ends COMPUTE.
   serial_divider #(.DATA_WIDTH(DATA_WIDTH)) u_div (
      .clock     (clock),
      .reset     (reset),
      .start     (in_hs_s),
      .dividend  (in_data[DATA_WIDTH-1:0]),
      .divisor   (in_data[2*DATA_WIDTH-1:DATA_WIDTH]),
      .busy      (div_busy_s),
      .done      (div_done_s),
      .quotient  (div_quo_s),
      .remainder (div_rem_s)
   );

   // Result selection for the beat about to be loaded into the output register.
   always_comb begin
      nxt_idx_s = (state_q == ST_EMIT) ? (idx_q + 3'd1) : 3'd0;
      case (nxt_idx_s)
         OP_ADD:   nxt_data_s = add_q;
         OP_SUB:   nxt_data_s = sub_q;
         OP_MUL:   nxt_data_s = mul_q;
         OP_DIV:   nxt_data_s = div_quo_s;
         OP_MOD:   nxt_data_s = div_rem_s;
`ifdef EVALUATOR_CLOG2_EN
         OP_CLOG2: nxt_data_s = clog2_q;
`endif
         default:  nxt_data_s = '0;
      endcase
   end

   // FSM next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      add_d       = add_q;
      sub_d       = sub_q;
      mul_d       = mul_q;
`ifdef EVALUATOR_CLOG2_EN
      clog2_d     = clog2_q;
`endif
      idx_d       = idx_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_dest_d  = out_dest_q;
      out_tlast_d = out_tlast_q;
      case (state_q)
         ST_IDLE: begin
            if (in_hs_s) begin
               a_d        = in_data[DATA_WIDTH-1:0];
               b_d        = in_data[2*DATA_WIDTH-1:DATA_WIDTH];
               in_ready_d = 1'b0;
               state_d    = ST_COMPUTE;
            end else begin
               in_ready_d = !div_busy_s;
            end
         end
         ST_COMPUTE: begin
            in_ready_d = 1'b0;
            add_d      = a_q + b_q;
            sub_d      = a_q - b_q;
            mul_d      = a_q * b_q;
`ifdef EVALUATOR_CLOG2_EN
            clog2_d    = DATA_WIDTH'(clog2_u64(64'(a_q)));
`endif
            // add_q is already settled here: COMPUTE lasts at least two cycles.
            if (div_done_s) begin
               state_d     = ST_EMIT;
               idx_d       = 3'd0;
               out_valid_d = 1'b1;
               out_data_d  = nxt_data_s;
               out_dest_d  = 3'd0;
               out_tlast_d = 1'b0;
            end else begin
               state_d = ST_COMPUTE;
            end
         end
         ST_EMIT: begin
            if (out_hs_s && (idx_q == LAST_OP)) begin
               state_d     = ST_IDLE;
               in_ready_d  = 1'b1;
               out_valid_d = 1'b0;
               out_data_d  = '0;
               out_dest_d  = 3'd0;
               out_tlast_d = 1'b0;
            end else if (out_hs_s) begin
               idx_d       = nxt_idx_s;
               out_data_d  = nxt_data_s;
               out_dest_d  = nxt_idx_s;
               out_tlast_d = (nxt_idx_s == LAST_OP);
            end else begin
               state_d = ST_EMIT;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         add_q       <= '0;
         sub_q       <= '0;
         mul_q       <= '0;
`ifdef EVALUATOR_CLOG2_EN
         clog2_q     <= '0;
`endif
         idx_q       <= 3'd0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_dest_q  <= 3'd0;
         out_tlast_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         add_q       <= add_d;
         sub_q       <= sub_d;
         mul_q       <= mul_d;
`ifdef EVALUATOR_CLOG2_EN
         clog2_q     <= clog2_d;
`endif
         idx_q       <= idx_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_dest_q  <= out_dest_d;
         out_tlast_q <= out_tlast_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_dest  = out_dest_q;
   assign out_tlast = out_tlast_q;

endmodule

// File: tb/tb_axis_expr_evaluator.sv
// tb_axis_expr_evaluator: randomized and directed self-checking bench for
// axis_expr_evaluator. Expected beats come from plain arithmetic on a and b.
module tb_axis_expr_evaluator;

   localparam int unsigned DW = 32;
`ifdef EVALUATOR_CLOG2_EN
   localparam int NB = 6;
`else
   localparam int NB = 5;
`endif

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic [2*DW-1:0] in_data = '0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [DW-1:0]   out_data;
   logic [2:0]      out_dest;
   logic            out_tlast;
   logic            out_valid;
   logic            out_ready = 1'b0;

   int checks = 0;
   int failures = 0;

   axis_expr_evaluator #(.DATA_WIDTH(DW)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_dest  (out_dest),
      .out_tlast (out_tlast),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input longint unsigned obs, input longint unsigned exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic longint unsigned ref_clog2(input longint unsigned a);
      longint unsigned n = 0;
      while ((64'd1 << n) < a) n++;
      return n;
   endfunction

   // Expected result of tag i for operands a, b.
   function automatic longint unsigned ref_result(input int i, input longint unsigned a, input longint unsigned b);
      longint unsigned mask = (64'd1 << DW) - 64'd1;
      case (i)
         0: return (a + b) & mask;
         1: return (a - b) & mask;
         2: return (a * b) & mask;
         3: return (b == 0) ? mask : (a / b);
         4: return (b == 0) ? a : (a % b);
         default: return ref_clog2(a) & mask;
      endcase
   endfunction

   // Performs the input handshake; returns positioned 1 time unit after it.
   task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b);
      int w = 0;
      while (!in_ready && w < 100) begin
         @(posedge clock); #1;
         w++;
      end
      check_eq("in_ready_wait", in_ready, 1);
      in_data  = {b, a};
      in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      check_eq("in_ready_low_after_accept", in_ready, 0);
   endtask

   // Collects one result set, checking latency, order, stability and tlast.
   task automatic collect(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit rand_rdy);
      int  k = 0;
      int  cyc = 0;
      bit  seen = 0;
      while (k < NB && cyc < 400) begin
         @(posedge clock); #1;
         cyc++;
         if (!seen && out_valid) begin
            seen = 1;
            check_eq("latency", cyc, DW);
         end
         if (seen) begin
            check_eq("out_valid", out_valid, 1);
            check_eq($sformatf("data_tag%0d", k), out_data, ref_result(k, a, b));
            check_eq("dest", out_dest, k);
            check_eq("tlast", out_tlast, (k == NB - 1));
         end
         check_eq("in_ready_busy", in_ready, 0);
         out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         if (seen && out_ready) k++;
      end
      check_eq("beats_done", k, NB);
      @(posedge clock); #1;
      out_ready = 1'b0;
      check_eq("valid_after_set", out_valid, 0);
      check_eq("in_ready_after_set", in_ready, 1);
   endtask

   task automatic run(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit rand_rdy);
      send(a, b);
      collect(a, b, rand_rdy);
   endtask

   // Pulses reset low and checks outputs clear at once and stay idle after release.
   task automatic pulse_reset();
      reset = 1'b0;
      #1;
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_in_ready", in_ready, 0);
      check_eq("rst_out_data", out_data, 0);
      check_eq("rst_out_dest", out_dest, 0);
      check_eq("rst_out_tlast", out_tlast, 0);
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      check_eq("post_rst_in_ready", in_ready, 1);
      for (int i = 0; i < 40; i++) begin
         check_eq("post_rst_no_beat", out_valid, 0);
         @(posedge clock); #1;
      end
   endtask

   initial begin
      logic [DW-1:0] ra, rb;
      int w;
      #1;
      check_eq("reset_in_ready", in_ready, 0);
      check_eq("reset_out_valid", out_valid, 0);
      check_eq("reset_out_data", out_data, 0);
      check_eq("reset_out_dest", out_dest, 0);
      check_eq("reset_out_tlast", out_tlast, 0);
      #20;
      reset = 1'b1;
      @(posedge clock); #1;

      run(32'd32, 32'd8, 1'b0);
      run(32'd7, 32'd0, 1'b0);
      run(32'd0, 32'd1, 1'b0);
      run(32'h10000, 32'h10000, 1'b0);
      run(32'd1, 32'd3, 1'b0);
      run(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      run(32'd32, 32'd8, 1'b1);

      // Reset in the middle of COMPUTE.
      send(32'd100, 32'd7);
      repeat (10) @(posedge clock);
      #1;
      pulse_reset();
      run(32'd100, 32'd7, 1'b0);

      // Reset in the middle of EMIT, with the first beat stalled.
      send(32'd55, 32'd6);
      w = 0;
      while (!out_valid && w < 100) begin
         @(posedge clock); #1;
         w++;
      end
      check_eq("emit_reached", out_valid, 1);
      repeat (3) @(posedge clock);
      #1;
      pulse_reset();
      run(32'd55, 32'd6, 1'b0);

      for (int n = 0; n < 20; n++) begin
         ra = $urandom;
         rb = (n % 4 == 0) ? 32'd0 : ((n % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom);
         if (n % 5 == 0) ra = 32'($urandom_range(0, 70));
         run(ra, rb, 1'(n % 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
